// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX and RX FIFOs.
//
// Register map (word offsets):
//   0 TXDATA  write: push write_data[7:0] into TX FIFO; read returns 0
//   1 RXDATA  read: {23'b0, valid, byte} and pop; returns 0 when empty
//   2 STATUS  {tx_overflow, frame_error, rx_overrun, rx_valid, tx_idle, tx_full};
//             write-1-to-clear on bits 3..5
//   3 DIVISOR clocks per bit, min 4; read returns {16'b0, DIVISOR}
//
// Ports:
//   clk          single clock
//   reset_n      asynchronous active-low reset
//   enable       bus access strobe (already decoded for this block)
//   write_enable access is a write when enable=1
//   address      word offset
//   write_data   store data (word stores only)
//   read_data    registered load data, updated the edge after a read
//   uart_rx      serial input, asynchronous to clk
//   uart_tx      serial output, idle high
module uart_mmio #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        write_enable,
  input  logic [1:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [15:0]     DivReset = 16'(CLK_DIV);
  localparam logic [15:0]     DivMin   = 16'd4;

  // Bus decode
  logic bus_wr, bus_rd, tx_wr, rx_rd, st_wr, div_wr;
  assign bus_wr = enable & write_enable;
  assign bus_rd = enable & ~write_enable;
  assign tx_wr  = bus_wr && (address == 2'd0);
  assign rx_rd  = bus_rd && (address == 2'd1);
  assign st_wr  = bus_wr && (address == 2'd2);
  assign div_wr = bus_wr && (address == 2'd3);

  logic unused_wd;
  assign unused_wd = ^write_data[31:16];

  // Divisor
  logic [15:0] divisor_q, divisor_d;
  always_comb begin
    divisor_d = divisor_q;
    if (div_wr) begin
      divisor_d = (write_data[15:0] < DivMin) ? DivMin : write_data[15:0];
    end
  end

  // TX FIFO
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_full, tx_empty, tx_pop, tx_push, tx_drop;

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  // A push into a full FIFO is accepted only if a pop frees a slot this cycle.
  assign tx_push  = tx_wr && (!tx_full || tx_pop);
  assign tx_drop  = tx_wr && tx_full && !tx_pop;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CntW'(1);
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q] <= write_data[7:0];
    end
  end

  // TX FSM
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_tick_q, tx_tick_d;
  logic [15:0] tx_len_q, tx_len_d;
  logic        tx_bit_done, tx_idle;

  // Each bit keeps the length latched at its start, so DIVISOR writes
  // only affect the next bit period.
  assign tx_bit_done = (tx_tick_q == tx_len_q - 16'd1);
  assign tx_idle     = tx_empty && (tx_state_q == TxIdle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_tick_d  = tx_tick_q + 16'd1;
    tx_len_d   = tx_len_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_tick_d = '0;
        if (!tx_empty) begin
          tx_state_d = TxStart;
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rptr_q];
          tx_len_d   = divisor_q;
        end
      end
      TxStart: begin
        if (tx_bit_done) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          tx_tick_d  = '0;
          tx_len_d   = divisor_q;
        end
      end
      TxData: begin
        if (tx_bit_done) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_tick_d  = '0;
          tx_len_d   = divisor_q;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TxStop: begin
        if (tx_bit_done) begin
          tx_tick_d = '0;
          tx_len_d  = divisor_q;
          if (!tx_empty) begin
            tx_state_d = TxStart;
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rptr_q];
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Output decoded straight from reset flops so reset forces the line high at once.
  always_comb begin
    uart_tx = 1'b1;
    unique case (tx_state_q)
      TxStart: uart_tx = 1'b0;
      TxData:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // RX synchronizer and falling-edge detect
  logic rx_sync1_q, rx_sync2_q, rx_prev_q, rx_s, rx_fall;
  assign rx_s    = rx_sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;

  // RX FSM
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [15:0] rx_tick_q, rx_tick_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic        rx_bit_done, rx_push_req, frame_err_set;

  assign rx_bit_done = (rx_tick_q == rx_len_q - 16'd1);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_bit_d      = rx_bit_q;
    rx_tick_d     = rx_tick_q + 16'd1;
    rx_len_d      = rx_len_q;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_tick_d = '0;
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_len_d   = {1'b0, divisor_q[15:1]};
        end
      end
      RxStart: begin
        if (rx_bit_done) begin
          rx_tick_d = '0;
          rx_len_d  = divisor_q;
          rx_bit_d  = '0;
          // Start bit high at mid-point: treat as a glitch.
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_bit_done) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_tick_d  = '0;
          rx_len_d   = divisor_q;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxStop: begin
        if (rx_bit_done) begin
          rx_tick_d  = '0;
          rx_state_d = RxIdle;
          if (rx_s) begin
            rx_push_req = 1'b1;
          end else begin
            frame_err_set = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX FIFO
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_full, rx_empty, rx_pop, rx_push, overrun_set;

  assign rx_full     = (rx_cnt_q == FullCnt);
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_pop      = rx_rd && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign overrun_set = rx_push_req && rx_full && !rx_pop;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CntW'(1);
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr_q] <= rx_shift_q;
    end
  end

  // Sticky status; a set in the same cycle as a clear wins.
  logic rx_overrun_q, rx_overrun_d;
  logic frame_error_q, frame_error_d;
  logic tx_overflow_q, tx_overflow_d;

  always_comb begin
    rx_overrun_d  = (rx_overrun_q  & ~(st_wr & write_data[3])) | overrun_set;
    frame_error_d = (frame_error_q & ~(st_wr & write_data[4])) | frame_err_set;
    tx_overflow_d = (tx_overflow_q & ~(st_wr & write_data[5])) | tx_drop;
  end

  logic [31:0] status;
  assign status = {26'b0, tx_overflow_q, frame_error_q, rx_overrun_q, !rx_empty,
                   tx_idle, tx_full};

  // Read data
  logic [31:0] read_data_d;
  always_comb begin
    read_data_d = read_data;
    if (bus_rd) begin
      unique case (address)
        2'd0: read_data_d = '0;
        2'd1: read_data_d = rx_empty ? 32'd0 : {23'b0, 1'b1, rx_mem[rx_rptr_q]};
        2'd2: read_data_d = status;
        2'd3: read_data_d = {16'b0, divisor_q};
        default: read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor_q     <= DivReset;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_state_q    <= TxIdle;
      tx_shift_q    <= '0;
      tx_bit_q      <= '0;
      tx_tick_q     <= '0;
      tx_len_q      <= DivReset;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_shift_q    <= '0;
      rx_bit_q      <= '0;
      rx_tick_q     <= '0;
      rx_len_q      <= DivReset;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_cnt_q      <= '0;
      rx_overrun_q  <= 1'b0;
      frame_error_q <= 1'b0;
      tx_overflow_q <= 1'b0;
      read_data     <= '0;
    end else begin
      divisor_q     <= divisor_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      tx_cnt_q      <= tx_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_shift_q    <= tx_shift_d;
      tx_bit_q      <= tx_bit_d;
      tx_tick_q     <= tx_tick_d;
      tx_len_q      <= tx_len_d;
      rx_sync1_q    <= uart_rx;
      rx_sync2_q    <= rx_sync1_q;
      rx_prev_q     <= rx_sync2_q;
      rx_state_q    <= rx_state_d;
      rx_shift_q    <= rx_shift_d;
      rx_bit_q      <= rx_bit_d;
      rx_tick_q     <= rx_tick_d;
      rx_len_q      <= rx_len_d;
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
      rx_cnt_q      <= rx_cnt_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_error_q <= frame_error_d;
      tx_overflow_q <= tx_overflow_d;
      read_data     <= read_data_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: directed sequence with random payloads,
// checked against a queue-based model of the register map and serial frames.
module tb_uart_mmio;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        write_enable;
  logic [1:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        uart_rx;
  logic        uart_tx;

  uart_mmio #(.CLK_DIV(434), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int div_cur = 434;

  // Model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit m_ovr, m_fe, m_txovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    enable = 1'b1; write_enable = 1'b1; address = a; write_data = d;
    tick(1);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    enable = 1'b1; write_enable = 1'b0; address = a;
    tick(1);
    enable = 1'b0;
    d = read_data;
  endtask

  // Status word built from the model: tx_full and tx_idle are passed in by the step.
  function automatic logic [31:0] exp_status(input bit full, input bit idle);
    exp_status = 32'(full) | (32'(idle) << 1) | (32'(rxq.size() > 0) << 2) |
                 (32'(m_ovr) << 3) | (32'(m_fe) << 4) | (32'(m_txovf) << 5);
  endfunction

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Called at the start of bit 0; samples each data bit mid-period, then stop.
  task automatic tx_capture(output logic [7:0] b, output logic stop);
    for (int i = 0; i < 8; i++) begin
      tick(i == 0 ? div_cur / 2 : div_cur);
      b[i] = uart_tx;
    end
    tick(div_cur);
    stop = uart_tx;
  endtask

  task automatic tx_frame(input string tag, input logic [7:0] exp);
    bit ok;
    logic [7:0] b;
    logic stop;
    wait_tx_start(ok);
    check({tag, "_start_seen"}, 32'(ok), 32'd1);
    tick(div_cur / 2);
    check({tag, "_start_bit"}, 32'(uart_tx), 32'd0);
    tick(div_cur - div_cur / 2);
    tx_capture(b, stop);
    check({tag, "_byte"}, 32'(b), 32'(exp));
    check({tag, "_stop"}, 32'(stop), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(div_cur);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(div_cur);
    end
    uart_rx = stop;
    tick(div_cur);
    uart_rx = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b, cap;
    logic        stop;
    int          cnt;
    bit          ok;

    enable = 1'b0; write_enable = 1'b0; address = '0; write_data = '0;
    uart_rx = 1'b1;
    reset_n = 1'b0;
    #23;
    check("rst_tx_high", 32'(uart_tx), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Reset values
    bus_read(2'd2, rd);
    check("rst_status", rd, exp_status(1'b0, 1'b1));
    bus_read(2'd3, rd);
    check("rst_divisor", rd, 32'd434);

    // Divisor clamp boundary
    bus_write(2'd3, 32'h0001_0002);
    bus_read(2'd3, rd);
    check("div_clamp", rd, 32'd4);
    bus_write(2'd3, 32'd8);
    div_cur = 8;
    bus_read(2'd3, rd);
    check("div_8", rd, 32'd8);
    tick(1);
    check("rd_hold", read_data, 32'd8);

    // 0xA5 frame: exact start-bit length, then bit values
    bus_write(2'd0, 32'hA5);
    wait_tx_start(ok);
    check("a5_start_seen", 32'(ok), 32'd1);
    cnt = 0;
    while (uart_tx === 1'b0 && cnt < 20) begin
      cnt++;
      tick(1);
    end
    check("a5_start_len", 32'(cnt), 32'd8);
    tx_capture(cap, stop);
    check("a5_byte", 32'(cap), 32'hA5);
    check("a5_stop", 32'(stop), 32'd1);
    tick(8);
    bus_read(2'd2, rd);
    check("a5_idle", rd, exp_status(1'b0, 1'b1));

    // Random single TX byte
    b = 8'($urandom);
    bus_write(2'd0, {24'($urandom), b});
    tx_frame("tx_rand", b);
    tick(8);

    // Five back-to-back writes fill the FIFO behind the first byte; sixth drops
    div_cur = 64;
    bus_write(2'd3, 32'd64);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      txq.push_back(b);
      bus_write(2'd0, 32'(b));
    end
    bus_write(2'd0, 32'hFF);
    m_txovf = 1'b1;
    bus_read(2'd2, rd);
    check("ovf_status", rd, exp_status(1'b1, 1'b0));
    while (txq.size() > 0) begin
      tx_frame("ovf_frame", txq.pop_front());
    end
    tick(64);
    bus_read(2'd2, rd);
    check("ovf_idle", rd, exp_status(1'b0, 1'b1));
    bus_write(2'd2, 32'h20);
    m_txovf = 1'b0;
    bus_read(2'd2, rd);
    check("ovf_clear", rd, exp_status(1'b0, 1'b1));

    // RX 0x3C
    div_cur = 8;
    bus_write(2'd3, 32'd8);
    send_frame(8'h3C, 1'b1);
    rxq.push_back(8'h3C);
    tick(4);
    bus_read(2'd2, rd);
    check("rx3c_status", rd, exp_status(1'b0, 1'b1));
    bus_read(2'd1, rd);
    check("rx3c_data", rd, {23'b0, 1'b1, rxq.pop_front()});
    tick(1);
    check("rx3c_hold", read_data, 32'h13C);
    bus_read(2'd1, rd);
    check("rx3c_empty", rd, 32'd0);

    // Random RX byte
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rxq.push_back(b);
    tick(4);
    bus_read(2'd1, rd);
    check("rx_rand", rd, {23'b0, 1'b1, rxq.pop_front()});

    // Five frames without reads: four retained, overrun set
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      if (rxq.size() < 4) rxq.push_back(b);
      else m_ovr = 1'b1;
    end
    tick(4);
    bus_read(2'd2, rd);
    check("ovr_status", rd, exp_status(1'b0, 1'b1));
    bus_write(2'd2, 32'h08);
    m_ovr = 1'b0;
    bus_read(2'd2, rd);
    check("ovr_clear", rd, exp_status(1'b0, 1'b1));
    while (rxq.size() > 0) begin
      b = rxq.pop_front();
      bus_read(2'd1, rd);
      check("ovr_byte", rd, {23'b0, 1'b1, b});
    end
    bus_read(2'd1, rd);
    check("ovr_drained", rd, 32'd0);

    // Low stop bit: frame error, nothing received
    send_frame(8'($urandom), 1'b0);
    m_fe = 1'b1;
    tick(4);
    bus_read(2'd2, rd);
    check("fe_status", rd, exp_status(1'b0, 1'b1));
    bus_write(2'd2, 32'h10);
    m_fe = 1'b0;

    // Two-clock glitch is rejected
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(100);
    bus_read(2'd2, rd);
    check("glitch_status", rd, exp_status(1'b0, 1'b1));
    bus_read(2'd1, rd);
    check("glitch_rxdata", rd, 32'd0);

    // Reset in the middle of a TX frame
    bus_write(2'd0, 32'h00);
    tick(20);
    check("mid_frame_low", 32'(uart_tx), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(uart_tx), 32'd1);
    check("rst_async_rd", read_data, 32'd0);
    tick(2);
    #2;
    reset_n = 1'b1;
    div_cur = 434;
    tick(10);
    check("post_rst_tx", 32'(uart_tx), 32'd1);
    bus_read(2'd2, rd);
    check("post_rst_status", rd, 32'h02);
    bus_read(2'd3, rd);
    check("post_rst_div", rd, 32'd434);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
